// File: rtl/ysyx_23060075_lut_cache.sv
// Writable key/value lookup table with a registered valid/ready lookup port.
// Misses return the default value sampled when the request is accepted.
module ysyx_23060075_lut_cache #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 32,
    parameter int CNT_LEN  = $clog2(NR_KEY) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [CNT_LEN-1:0]  count
);

    localparam int IDX_W = $clog2(NR_KEY);

    logic [NR_KEY-1:0]   valid_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [IDX_W-1:0]    vptr_q;
    logic [CNT_LEN-1:0]  count_q;

    logic [NR_KEY-1:0]   rd_match;
    logic [NR_KEY-1:0]   wr_match;
    logic [DATA_LEN-1:0] rd_data;
    logic                rd_hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                wr_hit;
    logic                full;
    logic                wr_do;
    logic                accept;

    always_comb begin
        rd_match = '0;
        wr_match = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            rd_match[i] = valid_q[i] && (key_q[i] == req_key);
            wr_match[i] = valid_q[i] && (key_q[i] == wr_key);
        end
    end

    // Keys are unique, so a plain OR of the matching entries is the read data.
    always_comb begin
        rd_data  = '0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (rd_match[i]) rd_data = rd_data | data_q[i];
            if (wr_match[i]) hit_idx = IDX_W'(i);
        end
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign rd_hit = |rd_match;
    assign wr_hit = |wr_match;
    assign full   = &valid_q;
    assign wr_do  = wr_en && !flush;
    assign wr_idx = wr_hit ? hit_idx : (full ? vptr_q : free_idx);

    always_ff @(posedge clk) begin
        if (wr_do) begin
            key_q[wr_idx]  <= wr_key;
            data_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            vptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            vptr_q  <= '0;
            count_q <= '0;
        end else if (wr_en && !wr_hit) begin
            if (full) begin
                vptr_q <= vptr_q + IDX_W'(1);
            end else begin
                valid_q[free_idx] <= 1'b1;
                count_q           <= count_q + CNT_LEN'(1);
            end
        end
    end

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_hit   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_hit   <= rd_hit;
            resp_data  <= rd_hit ? rd_data : default_out;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_ysyx_23060075_lut_cache.sv
// Directed bench for ysyx_23060075_lut_cache: table vectors plus
// hand sequences for same-cycle write/lookup, back-pressure and reset.
module tb_ysyx_23060075_lut_cache;

    localparam logic [1:0] OP_W = 2'd0;
    localparam logic [1:0] OP_L = 2'd1;
    localparam logic [1:0] OP_F = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  key;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_data;
        logic [2:0]  exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic [7:0]  wr_key;
    logic [31:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_key;
    logic [31:0] default_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[31];

    always #5 clk = ~clk;

    ysyx_23060075_lut_cache dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_key     (wr_key),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .default_out(default_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_hit   (resp_hit),
        .count      (count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0;
        wr_en = 1'b0;
        req_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] k,
                                input logic [31:0] d, input logic h,
                                input logic [31:0] ed, input logic [2:0] c);
        vec_t v;
        v.op = op; v.key = k; v.data = d;
        v.exp_hit = h; v.exp_data = ed; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(OP_L, 8'h12, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        vecs[1]  = mk(OP_W, 8'h12, 32'h11111111, 0, 0, 1);
        vecs[2]  = mk(OP_L, 8'h12, 32'h0, 1, 32'h11111111, 1);
        vecs[3]  = mk(OP_W, 8'h12, 32'h22222222, 0, 0, 1);
        vecs[4]  = mk(OP_L, 8'h12, 32'h0, 1, 32'h22222222, 1);
        vecs[5]  = mk(OP_F, 8'h77, 32'h77777777, 0, 0, 0);
        vecs[6]  = mk(OP_L, 8'h12, 32'hCAFE0000, 0, 32'hCAFE0000, 0);
        vecs[7]  = mk(OP_W, 8'h01, 32'hA1, 0, 0, 1);
        vecs[8]  = mk(OP_W, 8'h02, 32'hA2, 0, 0, 2);
        vecs[9]  = mk(OP_W, 8'h03, 32'hA3, 0, 0, 3);
        vecs[10] = mk(OP_W, 8'h04, 32'hA4, 0, 0, 4);
        vecs[11] = mk(OP_L, 8'h03, 32'h0, 1, 32'hA3, 4);
        vecs[12] = mk(OP_W, 8'h05, 32'hA5, 0, 0, 4);
        vecs[13] = mk(OP_L, 8'h01, 32'hD1, 0, 32'hD1, 4);
        vecs[14] = mk(OP_L, 8'h05, 32'h0, 1, 32'hA5, 4);
        vecs[15] = mk(OP_W, 8'h06, 32'hA6, 0, 0, 4);
        vecs[16] = mk(OP_L, 8'h02, 32'hD2, 0, 32'hD2, 4);
        vecs[17] = mk(OP_L, 8'h06, 32'h0, 1, 32'hA6, 4);
        vecs[18] = mk(OP_L, 8'h03, 32'h0, 1, 32'hA3, 4);
        vecs[19] = mk(OP_L, 8'h04, 32'h0, 1, 32'hA4, 4);
        vecs[20] = mk(OP_W, 8'h05, 32'hB5, 0, 0, 4);
        vecs[21] = mk(OP_W, 8'h07, 32'hA7, 0, 0, 4);
        vecs[22] = mk(OP_L, 8'h03, 32'hD3, 0, 32'hD3, 4);
        vecs[23] = mk(OP_L, 8'h04, 32'h0, 1, 32'hA4, 4);
        vecs[24] = mk(OP_L, 8'h05, 32'h0, 1, 32'hB5, 4);
        vecs[25] = mk(OP_F, 8'h40, 32'h40404040, 0, 0, 0);
        vecs[26] = mk(OP_L, 8'h40, 32'hD4, 0, 32'hD4, 0);
        vecs[27] = mk(OP_L, 8'h06, 32'hD6, 0, 32'hD6, 0);
        vecs[28] = mk(OP_W, 8'h00, 32'h00000F0F, 0, 0, 1);
        vecs[29] = mk(OP_L, 8'h00, 32'h0, 1, 32'h00000F0F, 1);
        vecs[30] = mk(OP_L, 8'h80, 32'hD8, 0, 32'hD8, 1);

        rst = 1'b1;
        idle();
        wr_key = '0; wr_data = '0; req_key = '0; default_out = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_hit", 32'(resp_hit), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_req_ready", 32'(req_ready), 1);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            idle();
            resp_ready = 1'b1;
            case (vecs[i].op)
                OP_W: begin
                    wr_en = 1'b1; wr_key = vecs[i].key; wr_data = vecs[i].data;
                end
                OP_F: begin
                    flush = 1'b1; wr_en = 1'b1;
                    wr_key = vecs[i].key; wr_data = vecs[i].data;
                end
                default: begin
                    req_valid = 1'b1; req_key = vecs[i].key;
                    default_out = vecs[i].data;
                end
            endcase
            @(posedge clk);
            @(negedge clk);
            idle();
            if (vecs[i].op == OP_L) begin
                chk($sformatf("v%0d_valid", i), 32'(resp_valid), 1);
                chk($sformatf("v%0d_hit", i), 32'(resp_hit),
                    32'(vecs[i].exp_hit));
                chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
            end
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
        end

        // Same-cycle write and lookup of 0x30 sees the old table.
        wr_en = 1'b1; wr_key = 8'h30; wr_data = 32'h30303030;
        req_valid = 1'b1; req_key = 8'h30; default_out = 32'h5555;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        chk("rbw_valid", 32'(resp_valid), 1);
        chk("rbw_hit", 32'(resp_hit), 0);
        chk("rbw_data", resp_data, 32'h5555);
        @(posedge clk);
        @(negedge clk);
        idle();
        chk("rbw_next_hit", 32'(resp_hit), 1);
        chk("rbw_next_data", resp_data, 32'h30303030);
        chk("rbw_count", 32'(count), 2);
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", 32'(resp_valid), 0);

        // Back-pressure: response held, no new accepts.
        req_valid = 1'b1; req_key = 8'h30; default_out = 32'h0;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_key = 8'h99; default_out = 32'h99999999;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_ready", c), 32'(req_ready), 0);
            chk($sformatf("bp%0d_valid", c), 32'(resp_valid), 1);
            chk($sformatf("bp%0d_hit", c), 32'(resp_hit), 1);
            chk($sformatf("bp%0d_data", c), resp_data, 32'h30303030);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b0_valid", 32'(resp_valid), 1);
        chk("b2b0_hit", 32'(resp_hit), 0);
        chk("b2b0_data", resp_data, 32'h99999999);
        req_key = 8'h00; default_out = 32'h1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b1_valid", 32'(resp_valid), 1);
        chk("b2b1_hit", 32'(resp_hit), 1);
        chk("b2b1_data", resp_data, 32'h00000F0F);
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid_low", 32'(resp_valid), 0);
        chk("hold_data", resp_data, 32'h00000F0F);
        chk("hold_hit", 32'(resp_hit), 1);

        // Reset while a response is pending.
        req_valid = 1'b1; req_key = 8'h30; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle();
        chk("pre_rst_valid", 32'(resp_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(resp_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_data", resp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_key = 8'h30; default_out = 32'h77;
        @(posedge clk);
        @(negedge clk);
        idle();
        chk("arst_lookup_hit", 32'(resp_hit), 0);
        chk("arst_lookup_data", resp_data, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060075_lut_cache.md
Name: ysyx_23060075_lut_cache

Overview:
- Parametrised, writable key/value lookup table; successor to the combinational default-output mux.
- Entries are stored in registers and written at run time rather than fed in as a static table.
- Lookups are registered behind a valid/ready handshake and return a hit flag. Misses return the default value.
- Serves NPC as a small associative store, e.g. for decode shortcuts, CSR address remap and TLB-like experiments.

Parameters:
- NR_KEY, 4, number of entries; ≥2, power of two.
- KEY_LEN, 8, key width in bits.
- DATA_LEN, 32, data width in bits.
- CNT_LEN, $clog2(NR_KEY)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  invalidate all entries.
- wr_en  in  1  write strobe.
- wr_key  in  KEY_LEN  key to insert or update.
- wr_data  in  DATA_LEN  data for wr_key.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  lookup request accepted when high with req_valid.
- req_key  in  KEY_LEN  lookup key.
- default_out  in  DATA_LEN  value returned on miss; sampled at request acceptance.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DATA_LEN  hit data or sampled default_out.
- resp_hit  out  1  1 = key found.
- count  out  CNT_LEN  number of valid entries, 0..NR_KEY.

Behaviour:
- Storage: NR_KEY entries, each {valid, key, data}, plus a victim pointer vptr of width log2(NR_KEY).
- Reset (asynchronous, rst=1):
  - All valid bits = 0; vptr = 0; count = 0.
  - resp_valid = 0; resp_data = 0; resp_hit = 0.
  - req_ready = 1 combinationally once rst deasserts.
  - A reset mid-operation drops any pending response.
- Priority per cycle: flush > write. A lookup is independent of both.
- Flush:
  - Next edge: all valid bits = 0, count = 0, vptr = 0.
  - A wr_en in the same cycle is dropped.
- Write (wr_en=1, flush=0), resolved in this order against current contents:
  - Hit (valid entry with key == wr_key): update that entry's data in place. count and vptr unchanged.
  - Miss with a free entry: fill the lowest-index invalid entry; count += 1.
  - Miss with table full: overwrite entry vptr; vptr = vptr+1, wrapping from NR_KEY-1 to 0; count unchanged.
- Duplicate keys: never created; the hit check covers all valid entries.
- Lookup handshake:
  - req_ready = !resp_valid || resp_ready (single-entry output register, full throughput).
  - Accept when req_valid && req_ready.
  - Next edge: resp_valid = 1, resp_hit = match, resp_data = matched data or default_out.
  - Latency: exactly 1 cycle from acceptance to resp_valid.
- Response hold:
  - resp_valid && !resp_ready: resp_data, resp_hit and resp_valid hold stable and no new request is accepted.
  - resp_ready=1 with no new accept: resp_valid = 0 next edge. resp_data and resp_hit retain their last value.
- Read-before-write:
  - A lookup accepted in the same cycle as a write or flush sees the table contents before that edge.
  - A lookup of key K accepted one cycle after a write of K hits.
- Match is a full KEY_LEN compare gated by valid. At most one entry matches, so no priority encoder is needed beyond a one-hot OR.
- count never exceeds NR_KEY and never underflows.
- Key widths: no truncation. Key 0 is a legal key.

Test Plan:
- Reset, then lookup key 0x12 with default_out=0xDEADBEEF:
  - resp_valid high 1 cycle after accept, resp_hit=0, resp_data=0xDEADBEEF, count=0.
- Write (0x12, 0x11111111), then a lookup next cycle:
  - resp_hit=1, resp_data=0x11111111, count=1.
  - A rewrite of 0x12 with 0x22222222 leaves count=1 and the next lookup returns 0x22222222.
- Write keys 1, 2, 3, 4, then key 5:
  - count=4 after four writes.
  - Key 5 replaces entry 0 (key 1): lookup 1 misses, lookup 5 hits, vptr=1.
  - Writing key 6 replaces key 2.
- Same-cycle write of 0x30 and accepted lookup of 0x30 -> miss. Lookup of 0x30 next cycle -> hit.
- Back-pressure:
  - Hold resp_ready=0 for 3 cycles with req_valid=1: req_ready=0, and resp_data/resp_hit stay stable.
  - Raise resp_ready: one request accepted per cycle thereafter, with back-to-back responses.
- flush together with wr_en:
  - count=0 and all lookups miss; the simultaneous write is not stored.
- Assert rst while resp_valid=1:
  - resp_valid=0 immediately (asynchronously) and count=0.
